// File: rtl/huf_pkg.sv
// Shared types and constants for the Huffman VLC packer.
package huf_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StMagic,
    StLength,
    StHeader,
    StPayload,
    StFlush,
    StTrailer,
    StDone
  } huf_state_e;

  localparam logic [31:0] HUF_MAGIC = 32'hD4C3B2A1;

  function automatic int unsigned huf_len_w(int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic bit huf_out_w_ok(int unsigned w);
    return (w == 32) || (w == 64);
  endfunction

endpackage

// File: rtl/huf_bit_accum.sv
// MSB-first bit buffer: concatenates enabled lanes of one beat and appends them
// below the bits already held; pop removes the top OUT_W bits.
module huf_bit_accum import huf_pkg::*; #(
  parameter int unsigned LANES   = 4,
  parameter int unsigned MAX_LEN = 15,
  parameter int unsigned OUT_W   = 32,
  parameter int unsigned LEN_W   = huf_len_w(MAX_LEN),
  localparam int unsigned CAT_W  = LANES * MAX_LEN,
  localparam int unsigned BUF_W  = OUT_W + CAT_W,
  localparam int unsigned FILL_W = $clog2(BUF_W + 1),
  localparam int unsigned SUM_W  = $clog2(CAT_W + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [LANES*MAX_LEN-1:0] codes,
  input  logic [LANES*LEN_W-1:0]   lens,
  input  logic [LANES-1:0]         mask,
  output logic [FILL_W-1:0]        fill,
  output logic [OUT_W-1:0]         top_word,
  output logic [SUM_W-1:0]         push_bits,
  output logic                     lane_err
);

  logic [BUF_W-1:0]  bits_q, bits_d, base;
  logic [FILL_W-1:0] fill_q, fill_d, base_fill;
  logic [CAT_W-1:0]  cat;
  logic [SUM_W-1:0]  cat_bits;
  logic [LANES-1:0]  lane_bad, eff_mask;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [LEN_W-1:0] l;
    assign l = lens[i*LEN_W +: LEN_W];
    // Range check only exists when the length field can encode > MAX_LEN.
    if ((2 ** LEN_W) - 1 > MAX_LEN) begin : g_rng
      assign lane_bad[i] = (l == '0) || (l > LEN_W'(MAX_LEN));
    end else begin : g_norng
      assign lane_bad[i] = (l == '0);
    end
  end

  assign eff_mask = mask & ~lane_bad;
  assign lane_err = |(mask & lane_bad);

  // Left-align each code in CAT_W; bits above its length fall off the top.
  always_comb begin
    cat      = '0;
    cat_bits = '0;
    for (int i = 0; i < LANES; i++) begin
      if (eff_mask[i]) begin
        cat = cat | ((CAT_W'(codes[i*MAX_LEN +: MAX_LEN])
                      << (CAT_W - int'(lens[i*LEN_W +: LEN_W]))) >> cat_bits);
        cat_bits = cat_bits + SUM_W'(lens[i*LEN_W +: LEN_W]);
      end
    end
  end

  always_comb begin
    base      = pop ? (bits_q << OUT_W) : bits_q;
    base_fill = pop ? (fill_q - FILL_W'(OUT_W)) : fill_q;
    bits_d    = base;
    fill_d    = base_fill;
    if (push) begin
      bits_d = base | ({cat, {OUT_W{1'b0}}} >> base_fill);
      fill_d = base_fill + FILL_W'(cat_bits);
    end
    if (clear) begin
      bits_d = '0;
      fill_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bits_q <= '0;
      fill_q <= '0;
    end else begin
      bits_q <= bits_d;
      fill_q <= fill_d;
    end
  end

  assign fill      = fill_q;
  assign top_word  = bits_q[BUF_W-1 -: OUT_W];
  assign push_bits = push ? cat_bits : '0;

endmodule

// File: rtl/huf_vlc_packer.sv
// Block framer and VLC packer: magic, length, header, packed payload, optional trailer.
// Define HUF_TRAILER_EN to append a bit-count trailer word carrying out_last.
module huf_vlc_packer import huf_pkg::*; #(
  parameter int unsigned LANES   = 4,
  parameter int unsigned MAX_LEN = 15,
  parameter int unsigned OUT_W   = 32,
  parameter logic [31:0] MAGIC   = HUF_MAGIC,
  localparam int unsigned LEN_W  = huf_len_w(MAX_LEN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [31:0]              src_len,
  input  logic [OUT_W-1:0]         hdr_data,
  input  logic                     hdr_valid,
  input  logic                     hdr_last,
  output logic                     hdr_ready,
  input  logic [LANES*MAX_LEN-1:0] sym_code,
  input  logic [LANES*LEN_W-1:0]   sym_len,
  input  logic [LANES-1:0]         sym_mask,
  input  logic                     sym_valid,
  input  logic                     sym_last,
  output logic                     sym_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_valid,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [31:0]              bit_count
);

  localparam int unsigned CAT_W  = LANES * MAX_LEN;
  localparam int unsigned FILL_W = $clog2(OUT_W + CAT_W + 1);
  localparam int unsigned SUM_W  = $clog2(CAT_W + 1);
  localparam logic [FILL_W-1:0] FillOut = FILL_W'(OUT_W);

`ifdef HUF_TRAILER_EN
  localparam bit TrailerEn = 1'b1;
`else
  localparam bit TrailerEn = 1'b0;
`endif

  if (!huf_out_w_ok(OUT_W)) begin : g_bad_out_w
    $error("huf_vlc_packer: OUT_W must be 32 or 64");
  end

  huf_state_e        state_q, state_d;
  logic [OUT_W-1:0]  out_data_q, ld_data, top_word;
  logic              out_valid_q, out_last_q, ld_last, load;
  logic [31:0]       src_len_q, bit_count_q;
  logic              err_q, last_seen_q;
  logic              can_load, start_acc, acc_push, acc_pop, acc_clear, lane_err;
  logic [FILL_W-1:0] fill;
  logic [SUM_W-1:0]  push_bits;
  logic [32:0]       bc_sum;

  huf_bit_accum #(
    .LANES  (LANES),
    .MAX_LEN(MAX_LEN),
    .OUT_W  (OUT_W),
    .LEN_W  (LEN_W)
  ) u_accum (
    .clk      (clk),
    .rst      (rst),
    .clear    (acc_clear),
    .push     (acc_push),
    .pop      (acc_pop),
    .codes    (sym_code),
    .lens     (sym_len),
    .mask     (sym_mask),
    .fill     (fill),
    .top_word (top_word),
    .push_bits(push_bits),
    .lane_err (lane_err)
  );

  assign can_load = !out_valid_q || out_ready;
  assign acc_push = sym_valid && sym_ready;
  assign bc_sum   = {1'b0, bit_count_q} + 33'(push_bits);

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    ld_data   = '0;
    ld_last   = 1'b0;
    acc_pop   = 1'b0;
    acc_clear = 1'b0;
    hdr_ready = 1'b0;
    sym_ready = 1'b0;
    start_acc = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          start_acc = 1'b1;
          acc_clear = 1'b1;
          state_d   = StMagic;
        end
      end
      StMagic: begin
        if (can_load) begin
          load    = 1'b1;
          ld_data = OUT_W'(MAGIC);
          state_d = StLength;
        end
      end
      StLength: begin
        if (can_load) begin
          load    = 1'b1;
          ld_data = OUT_W'(src_len_q);
          state_d = StHeader;
        end
      end
      StHeader: begin
        hdr_ready = can_load;
        if (hdr_valid && can_load) begin
          load    = 1'b1;
          ld_data = hdr_data;
          if (hdr_last) state_d = StPayload;
        end
      end
      StPayload: begin
        sym_ready = !last_seen_q && (fill < FillOut) && can_load;
        if (fill >= FillOut) begin
          if (can_load) begin
            load    = 1'b1;
            acc_pop = 1'b1;
            ld_data = top_word;
            // Without a trailer the word that empties the buffer ends the block.
            ld_last = !TrailerEn && last_seen_q && (fill == FillOut);
          end
        end else if (last_seen_q) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (fill == '0) begin
          state_d = TrailerEn ? StTrailer : StDone;
        end else if (can_load) begin
          load      = 1'b1;
          acc_clear = 1'b1;
          ld_data   = top_word;
          ld_last   = !TrailerEn;
          state_d   = TrailerEn ? StTrailer : StDone;
        end
      end
      StTrailer: begin
        if (can_load) begin
          load    = 1'b1;
          ld_data = OUT_W'(bit_count_q);
          ld_last = 1'b1;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      src_len_q   <= '0;
      bit_count_q <= '0;
      err_q       <= 1'b0;
      last_seen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= ld_data;
        out_last_q  <= ld_last;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
      if (start_acc) begin
        src_len_q   <= src_len;
        bit_count_q <= '0;
        err_q       <= 1'b0;
        last_seen_q <= 1'b0;
      end else if (acc_push) begin
        bit_count_q <= bc_sum[32] ? 32'hFFFF_FFFF : bc_sum[31:0];
        if (lane_err) err_q <= 1'b1;
        if (sym_last) last_seen_q <= 1'b1;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != StIdle) && (state_q != StDone);
  assign done      = (state_q == StDone);
  assign err       = err_q;
  assign bit_count = bit_count_q;

endmodule
